gr_heep_ext_irq_ctrl: RTL and testbench

- Parametrised external interrupt controller for GR-HEEP. It replaces the fixed external interrupt count with NumIrq configurable sources.
- Per source it provides: input synchronisation, level or rising-edge mode, enable, pending, and a claim register.
- Sits between the external peripherals and one core-v-mini-mcu fast interrupt line, and is programmed over a simple always-grant register port on the external peripheral bus.

---
 rtl/gr_heep_ext_irq_ctrl.sv | 142 ++++++++++++++
 tb/tb_gr_heep_ext_irq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gr_heep_ext_irq_ctrl.sv
// rtl/gr_heep_ext_irq_ctrl.sv - parametrised external interrupt controller with sync, mode, enable, pending and claim
module gr_heep_ext_irq_ctrl #(
    parameter int NumIrq     = 4,
    parameter int SyncStages = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumIrq-1:0] irq_src_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [3:0]        addr_i,
    input  logic [31:0]       wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              irq_o,
    output logic [4:0]        irq_id_o
);

    // Registers are kept 32 bits wide; bits at NumIrq and above are held at 0 by this mask.
    localparam logic [31:0] IrqMask = 32'((64'd1 << NumIrq) - 64'd1);

    localparam logic [3:0] AddrEnable  = 4'h0;
    localparam logic [3:0] AddrMode    = 4'h4;
    localparam logic [3:0] AddrPending = 4'h8;
    localparam logic [3:0] AddrClaim   = 4'hC;

    logic [NumIrq-1:0] sync_q [SyncStages];
    logic [NumIrq-1:0] sync_d [SyncStages];
    logic [31:0]       s_prev_q, s_prev_d;
    logic [31:0]       enable_q, enable_d;
    logic [31:0]       mode_q, mode_d;
    logic [31:0]       pend_q, pend_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              irq_q, irq_d;
    logic [4:0]        irq_id_q, irq_id_d;

    logic [31:0] s;
    logic [31:0] active;
    logic [31:0] w1c;
    logic [31:0] claim_clr;
    logic [31:0] edge_pend;
    logic [31:0] claim_word;
    logic [4:0]  claim_id;
    logic        claim_valid;
    logic        wr_en;
    logic        rd_en;

    assign gnt_o    = req_i;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign irq_o    = irq_q;
    assign irq_id_o = irq_id_q;

    always_comb begin
        sync_d[0] = irq_src_i;
        for (int k = 1; k < SyncStages; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        s        = 32'(sync_q[SyncStages-1]);
        s_prev_d = s;

        active   = pend_q & enable_q;
        claim_id = 5'd0;
        // Scanning downwards leaves the lowest set index as the final assignment.
        for (int i = 31; i >= 0; i--) begin
            if (active[i]) begin
                claim_id = 5'(i);
            end
        end
        claim_valid = |active;
        claim_word  = {claim_valid, 26'd0, claim_id};

        wr_en    = req_i & we_i;
        rd_en    = req_i & ~we_i;
        enable_d = enable_q;
        mode_d   = mode_q;
        w1c      = 32'd0;
        if (wr_en) begin
            case (addr_i)
                AddrEnable:  enable_d = wdata_i & IrqMask;
                AddrMode:    mode_d   = wdata_i & IrqMask;
                AddrPending: w1c      = wdata_i & IrqMask;
                default:     ;
            endcase
        end

        claim_clr = 32'd0;
        if (rd_en && addr_i == AddrClaim && claim_valid) begin
            claim_clr = 32'd1 << claim_id;
        end

        // A new rising edge outranks any clear arriving in the same cycle.
        edge_pend = (pend_q & ~(w1c | claim_clr)) | (s & ~s_prev_q);
        pend_d    = ((mode_q & edge_pend) | (~mode_q & s)) & ~(mode_q ^ mode_d) & IrqMask;

        rvalid_d = req_i;
        rdata_d  = 32'd0;
        if (rd_en) begin
            case (addr_i)
                AddrEnable:  rdata_d = enable_q;
                AddrMode:    rdata_d = mode_q;
                AddrPending: rdata_d = pend_q;
                AddrClaim:   rdata_d = claim_word;
                default:     rdata_d = 32'd0;
            endcase
        end

        irq_d    = claim_valid;
        irq_id_d = claim_id;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < SyncStages; k++) begin
                sync_q[k] <= '0;
            end
            s_prev_q <= 32'd0;
            enable_q <= 32'd0;
            mode_q   <= 32'd0;
            pend_q   <= 32'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            irq_q    <= 1'b0;
            irq_id_q <= 5'd0;
        end else begin
            for (int k = 0; k < SyncStages; k++) begin
                sync_q[k] <= sync_d[k];
            end
            s_prev_q <= s_prev_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
        end
    end

endmodule

// File: tb/tb_gr_heep_ext_irq_ctrl.sv
// tb/tb_gr_heep_ext_irq_ctrl.sv - directed self-checking bench for gr_heep_ext_irq_ctrl
module tb_gr_heep_ext_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [3:0]  irq_src_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        irq_o;
    logic [4:0]  irq_id_o;

    int checks = 0;
    int errors = 0;

    gr_heep_ext_irq_ctrl #(.NumIrq(4), .SyncStages(2)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .irq_src_i (irq_src_i),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .irq_o     (irq_o),
        .irq_id_o  (irq_id_o)
    );

    always #5 clk_i = ~clk_i;

    // Called 1 time unit after a rising edge; returns 1 time unit after the edge that accepts the request.
    task automatic bus(input logic we, input logic [3:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic rv);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = a;
        wdata_i = wd;
        @(posedge clk_i); #1;
        req_i   = 1'b0;
        we_i    = 1'b0;
        rv      = rvalid_o;
        rd      = rdata_o;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic        rv;
        logic [3:0]  addrs [4];
        addrs = '{4'h0, 4'h4, 4'h8, 4'hC};
        rst_ni = 1'b0; irq_src_i = 4'h0; req_i = 1'b0; we_i = 1'b0; addr_i = 4'h0; wdata_i = 32'h0;
        cycles(3);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (irq_o !== 1'b0 || irq_id_o !== 5'd0 || rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: irq=%b id=%0d rvalid=%b rdata=%h, required 0/0/0/0", irq_o, irq_id_o, rvalid_o, rdata_o);
        end
        req_i = 1'b1; we_i = 1'b0; addr_i = 4'h0; #1;
        checks++;
        if (gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL grant_comb: gnt=%b, required 1", gnt_o);
        end
        req_i = 1'b0; #1;
        checks++;
        if (gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL grant_idle: gnt=%b, required 0", gnt_o);
        end
        for (int i = 0; i < 4; i++) begin
            bus(1'b0, addrs[i], 32'h0, rd, rv);
            checks++;
            if (rv !== 1'b1 || rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_read_%h: rvalid=%b rdata=%h, required 1/00000000", addrs[i], rv, rd);
            end
        end
        cycles(1);
        checks++;
        if (rvalid_o !== 1'b0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_single_pulse: rvalid=%b irq=%b, required 0/0", rvalid_o, irq_o);
        end
    endtask

    task automatic test_level_latency;
        logic [31:0] rd;
        logic        rv;
        int          n;
        bus(1'b1, 4'h0, 32'hF, rd, rv);
        bus(1'b1, 4'h4, 32'h0, rd, rv);
        irq_src_i[2] = 1'b1;
        n = 99;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_i); #1;
            if (irq_o === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n !== 4 || irq_id_o !== 5'd2) begin
            errors++;
            $display("FAIL level_rise_latency: edges=%0d id=%0d, required 4/2", n, irq_id_o);
        end
        irq_src_i[2] = 1'b0;
        n = 99;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_i); #1;
            if (irq_o === 1'b0) begin n = i; break; end
        end
        checks++;
        if (n !== 4 || irq_id_o !== 5'd0) begin
            errors++;
            $display("FAIL level_fall_latency: edges=%0d id=%0d, required 4/0", n, irq_id_o);
        end
    endtask

    task automatic test_edge_claim;
        logic [31:0] rd;
        logic        rv;
        bus(1'b1, 4'h4, 32'h1, rd, rv);
        bus(1'b1, 4'h0, 32'h1, rd, rv);
        irq_src_i[0] = 1'b1;
        cycles(3);
        irq_src_i[0] = 1'b0;
        cycles(5);
        bus(1'b0, 4'h8, 32'h0, rd, rv);
        checks++;
        if (rd !== 32'h1 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL edge_pending: rdata=%h irq=%b, required 00000001/1", rd, irq_o);
        end
        bus(1'b0, 4'hC, 32'h0, rd, rv);
        checks++;
        if (rd !== 32'h8000_0000) begin
            errors++;
            $display("FAIL edge_claim: rdata=%h, required 80000000", rd);
        end
        bus(1'b0, 4'h8, 32'h0, rd, rv);
        checks++;
        if (rd !== 32'h0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL edge_after_claim: rdata=%h irq=%b, required 00000000/0", rd, irq_o);
        end
    endtask

    task automatic test_multi_claim;
        logic [31:0] rd;
        logic        rv;
        logic [31:0] exp [3];
        exp = '{32'h8000_0001, 32'h8000_0003, 32'h0000_0000};
        bus(1'b1, 4'h4, 32'hF, rd, rv);
        bus(1'b1, 4'h0, 32'hF, rd, rv);
        irq_src_i = 4'b1010;
        cycles(2);
        irq_src_i = 4'b0000;
        cycles(5);
        checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd1) begin
            errors++;
            $display("FAIL multi_irq_id: irq=%b id=%0d, required 1/1", irq_o, irq_id_o);
        end
        for (int i = 0; i < 3; i++) begin
            bus(1'b0, 4'hC, 32'h0, rd, rv);
            checks++;
            if (rd !== exp[i]) begin
                errors++;
                $display("FAIL multi_claim_%0d: rdata=%h, required %h", i, rd, exp[i]);
            end
        end
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL multi_claim_irq: irq=%b, required 0", irq_o);
        end
    endtask

    task automatic test_set_wins;
        logic [31:0] rd;
        logic        rv;
        bus(1'b1, 4'h0, 32'h1, rd, rv);
        irq_src_i[0] = 1'b1;
        cycles(2);
        bus(1'b1, 4'h8, 32'h1, rd, rv);
        bus(1'b0, 4'h8, 32'h0, rd, rv);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL set_wins: pending=%h, required 00000001", rd);
        end
        bus(1'b1, 4'h8, 32'h1, rd, rv);
        bus(1'b0, 4'h8, 32'h0, rd, rv);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL w1c_clear: pending=%h, required 00000000", rd);
        end
        irq_src_i[0] = 1'b0;
        cycles(4);
    endtask

    task automatic test_enable_gate;
        logic [31:0] rd;
        logic        rv;
        bus(1'b1, 4'h0, 32'h0, rd, rv);
        irq_src_i[0] = 1'b1;
        cycles(2);
        irq_src_i[0] = 1'b0;
        cycles(5);
        bus(1'b0, 4'h8, 32'h0, rd, rv);
        checks++;
        if (rd !== 32'h1 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL disabled_gate: pending=%h irq=%b, required 00000001/0", rd, irq_o);
        end
        bus(1'b1, 4'h0, 32'h1, rd, rv);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL enable_write_cycle: irq=%b, required 0", irq_o);
        end
        cycles(1);
        checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd0) begin
            errors++;
            $display("FAIL enable_rise: irq=%b id=%0d, required 1/0", irq_o, irq_id_o);
        end
        bus(1'b1, 4'h4, 32'hE, rd, rv);
        bus(1'b0, 4'h8, 32'h0, rd, rv);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL mode_change_clear: pending=%h, required 00000000", rd);
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] rd;
        logic        rv;
        bus(1'b1, 4'h3, 32'hFFFF_FFFF, rd, rv);
        checks++;
        if (rv !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_write: rvalid=%b rdata=%h, required 1/00000000", rv, rd);
        end
        bus(1'b0, 4'h3, 32'h0, rd, rv);
        checks++;
        if (rv !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read: rvalid=%b rdata=%h, required 1/00000000", rv, rd);
        end
        bus(1'b0, 4'h0, 32'h0, rd, rv);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL unmapped_enable_kept: rdata=%h, required 00000001", rd);
        end
        bus(1'b0, 4'h4, 32'h0, rd, rv);
        checks++;
        if (rd !== 32'hE) begin
            errors++;
            $display("FAIL unmapped_mode_kept: rdata=%h, required 0000000e", rd);
        end
        bus(1'b1, 4'h0, 32'hFFFF_FFFF, rd, rv);
        bus(1'b0, 4'h0, 32'h0, rd, rv);
        checks++;
        if (rd !== 32'hF) begin
            errors++;
            $display("FAIL enable_width_mask: rdata=%h, required 0000000f", rd);
        end
    endtask

    initial begin
        test_reset();
        test_level_latency();
        test_edge_claim();
        test_multi_claim();
        test_set_wins();
        test_enable_gate();
        test_unmapped();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
